// File: rtl/sync_ram_param.sv
// ---------------------------------------------------------------------------
// sync_ram_param
//   Parametrised single-port synchronous RAM used as general scratch storage
//   between the register/bus front end and local datapaths.
//   - DATA_W-bit words, 2**ADDR_W deep, per-byte write enables.
//   - Registered read (one-cycle latency) qualified by rd_valid.
//   - WRITE_FIRST selects old (0) or merged new (1) data on read-during-write.
//   - The array is cleared to CLEAR_VAL by a sequential sweep, one word per
//     cycle, after reset and whenever clr_req is pulsed while idle.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   addr      in   word address
//   CS        in   chip select (qualifies WE and RD)
//   WE        in   write enable
//   RD        in   read enable
//   BE        in   byte enables, bit i covers dataIn[8i+7:8i]
//   dataIn    in   write data
//   clr_req   in   single-cycle request to start a clear sweep
//   dataOut   out  registered read data (zero when no read was issued)
//   rd_valid  out  dataOut holds the read issued in the previous cycle
//   busy      out  clear sweep in progress, accesses are ignored
//   drop      out  one-cycle pulse: an access was discarded while busy
// ---------------------------------------------------------------------------
module sync_ram_param #(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 2,
  parameter bit                WRITE_FIRST = 1'b0,
  parameter logic [DATA_W-1:0] CLEAR_VAL   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  CS,
  input  logic                  WE,
  input  logic                  RD,
  input  logic [DATA_W/8-1:0]   BE,
  input  logic [DATA_W-1:0]     dataIn,
  input  logic                  clr_req,
  output logic [DATA_W-1:0]     dataOut,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  drop
);

  localparam int DEPTH  = 2**ADDR_W;
  localparam int NBYTES = DATA_W / 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_clr_ptr, w_clr_ptr_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [DATA_W-1:0] w_old;
  logic [DATA_W-1:0] w_merged;
  logic              w_busy;
  logic              w_access;
  logic              w_wr;
  logic              w_rd;

  assign w_busy   = (r_state == ST_CLEAR);
  assign w_access = CS & (WE | RD);
  assign w_wr     = ~w_busy & CS & WE;
  assign w_rd     = ~w_busy & CS & RD;
  assign busy     = w_busy;

  // Single port: the read and the write of a cycle always share addr, so the
  // merged word is both the value written and the write-first read result.
  assign w_old = r_mem[addr];

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_merged = w_old;
    for (int i = 0; i < NBYTES; i++) begin
      if (BE[i]) w_merged[8*i +: 8] = dataIn[8*i +: 8];
    end
  end

  // Next-state logic: the sweep walks clr_ptr 0..DEPTH-1, then returns to
  // IDLE; the pointer wraps back to 0 by natural ADDR_W-bit overflow.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    unique case (r_state)
      ST_CLEAR: begin
        w_clr_ptr_nxt = r_clr_ptr + 1'b1;
        if (r_clr_ptr == ADDR_W'(DEPTH - 1)) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (clr_req) begin
          w_state_nxt   = ST_CLEAR;
          w_clr_ptr_nxt = '0;
        end
      end
      default: begin
        w_state_nxt   = ST_CLEAR;
        w_clr_ptr_nxt = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end
  end

  // NOTE: the array has no reset branch so it maps onto RAM macros; the
  // clear sweep establishes known contents instead.
  always_ff @(posedge clk) begin
    if (w_busy) begin
      r_mem[r_clr_ptr] <= CLEAR_VAL;
    end else if (w_wr) begin
      r_mem[addr] <= w_merged;
    end
  end

  // Read register: zero unless a read was accepted, so consumers may OR
  // several RAM outputs together without extra muxing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dataOut  <= '0;
      rd_valid <= 1'b0;
      drop     <= 1'b0;
    end else begin
      if (w_rd) begin
        dataOut <= (WRITE_FIRST && w_wr) ? w_merged : w_old;
      end else begin
        dataOut <= '0;
      end
      rd_valid <= w_rd;
      drop     <= w_busy & w_access;
    end
  end

endmodule

// File: tb/tb_sync_ram_param.sv
// ---------------------------------------------------------------------------
// tb_sync_ram_param
//   Drives one shared stimulus stream into three configurations of
//   sync_ram_param and compares each against its own behavioural model:
//     k=0: DATA_W=8,  ADDR_W=2, WRITE_FIRST=0, CLEAR_VAL=0
//     k=1: DATA_W=32, ADDR_W=2, WRITE_FIRST=0, CLEAR_VAL=0
//     k=2: DATA_W=32, ADDR_W=3, WRITE_FIRST=1, CLEAR_VAL=0xFF
//   The model keeps the array as a plain array, the sweep as a count of
//   remaining words, and recomputes the expected outputs each edge.
// ---------------------------------------------------------------------------
module tb_sync_ram_param;

  logic        clk;
  logic        reset;
  logic [2:0]  addr;
  logic        CS, WE, RD;
  logic [3:0]  BE;
  logic [31:0] dataIn;
  logic        clr_req;

  logic [7:0]  do0;
  logic [31:0] do1, do2;
  logic        v0, v1, v2;
  logic        b0, b1, b2;
  logic        d0, d1, d2;

  int n_vec = 0;
  int n_err = 0;

  sync_ram_param #(.DATA_W(8), .ADDR_W(2), .WRITE_FIRST(1'b0), .CLEAR_VAL(8'h00)) u0 (
    .clk(clk), .reset(reset), .addr(addr[1:0]), .CS(CS), .WE(WE), .RD(RD),
    .BE(BE[0:0]), .dataIn(dataIn[7:0]), .clr_req(clr_req),
    .dataOut(do0), .rd_valid(v0), .busy(b0), .drop(d0));

  sync_ram_param #(.DATA_W(32), .ADDR_W(2), .WRITE_FIRST(1'b0), .CLEAR_VAL(32'h0)) u1 (
    .clk(clk), .reset(reset), .addr(addr[1:0]), .CS(CS), .WE(WE), .RD(RD),
    .BE(BE), .dataIn(dataIn), .clr_req(clr_req),
    .dataOut(do1), .rd_valid(v1), .busy(b1), .drop(d1));

  sync_ram_param #(.DATA_W(32), .ADDR_W(3), .WRITE_FIRST(1'b1), .CLEAR_VAL(32'hFF)) u2 (
    .clk(clk), .reset(reset), .addr(addr), .CS(CS), .WE(WE), .RD(RD),
    .BE(BE), .dataIn(dataIn), .clr_req(clr_req),
    .dataOut(do2), .rd_valid(v2), .busy(b2), .drop(d2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  int          m_depth [3] = '{4, 4, 8};
  int          m_nb    [3] = '{1, 4, 4};
  bit          m_wf    [3] = '{1'b0, 1'b0, 1'b1};
  logic [31:0] m_clr   [3] = '{32'h0, 32'h0, 32'hFF};
  logic [31:0] m_mem   [3][8];
  int          m_left  [3];
  logic [31:0] e_do    [3];
  bit          e_v     [3];
  bit          e_drop  [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_left[k] = m_depth[k];
      e_do[k]   = '0;
      e_v[k]    = 1'b0;
      e_drop[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int          a;
      logic [31:0] old_w, new_w;
      bit          wr, rd;
      if (!reset) begin
        m_left[k] = m_depth[k];
        e_do[k] = '0; e_v[k] = 1'b0; e_drop[k] = 1'b0;
        continue;
      end
      a = int'(addr) % m_depth[k];
      if (m_left[k] > 0) begin
        e_drop[k] = CS && (WE || RD);
        m_mem[k][m_depth[k] - m_left[k]] = m_clr[k];
        m_left[k]--;
        e_do[k] = '0;
        e_v[k]  = 1'b0;
      end else begin
        old_w = m_mem[k][a];
        new_w = old_w;
        for (int l = 0; l < m_nb[k]; l++)
          if (BE[l]) new_w[8*l +: 8] = dataIn[8*l +: 8];
        wr = CS && WE;
        rd = CS && RD;
        if (wr) m_mem[k][a] = new_w;
        e_v[k]    = rd;
        e_do[k]   = rd ? ((m_wf[k] && wr) ? new_w : old_w) : 32'h0;
        e_drop[k] = 1'b0;
        if (clr_req) m_left[k] = m_depth[k];
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] got_do [3];
    logic        got_v  [3], got_b [3], got_d [3];
    got_do = '{32'(do0), do1, do2};
    got_v  = '{v0, v1, v2};
    got_b  = '{b0, b1, b2};
    got_d  = '{d0, d1, d2};
    for (int k = 0; k < 3; k++) begin
      check($sformatf("u%0d.busy", k),     32'(got_b[k]), 32'(m_left[k] > 0));
      check($sformatf("u%0d.dataOut", k),  got_do[k],     e_do[k]);
      check($sformatf("u%0d.rd_valid", k), 32'(got_v[k]), 32'(e_v[k]));
      check($sformatf("u%0d.drop", k),     32'(got_d[k]), 32'(e_drop[k]));
    end
  endtask

  // One clock: model follows the edge, outputs are compared at the negedge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    CS = 0; WE = 0; RD = 0; BE = '0; dataIn = '0; clr_req = 0; addr = '0;
  endtask

  task automatic do_write(input int a, input logic [31:0] d, input logic [3:0] be);
    idle_inputs();
    CS = 1; WE = 1; addr = 3'(a); dataIn = d; BE = be;
    cycle();
  endtask

  task automatic do_read(input int a);
    idle_inputs();
    CS = 1; RD = 1; addr = 3'(a);
    cycle();
  endtask

  task automatic assert_reset();
    reset = 1'b0;
    model_reset();
    #1;
    compare_all();
  endtask

  int n;

  initial begin
    idle_inputs();
    reset = 1'b0;
    model_reset();
    repeat (3) cycle();

    // Release reset; a write while sweeping is dropped.
    @(negedge clk);
    reset = 1'b1;
    do_write(1, 32'hAA, 4'hF);
    check("drop_during_sweep", 32'(d0), 32'd1);
    idle_inputs();
    n = 1;
    while (b0 && n < 20) begin
      n++;
      cycle();
    end
    check("sweep_len_depth4", 32'(n), 32'd4);
    n = 0;
    while (b2 && n < 20) begin
      n++;
      cycle();
    end

    // Cleared words read zero, including the dropped-write address.
    for (int i = 0; i < 4; i++) begin
      do_read(i);
      check("clr_read8", 32'(do0), 32'h0);
      check("clr_valid8", 32'(v0), 32'd1);
    end

    // Byte-enable merge.
    do_write(2, 32'h11223344, 4'b1111);
    do_write(2, 32'hAABBCCDD, 4'b0101);
    do_read(2);
    check("be_merge", do1, 32'h11BB33DD);

    // Read-during-write in both modes.
    do_write(3, 32'h55, 4'hF);
    idle_inputs();
    CS = 1; WE = 1; RD = 1; addr = 3'd3; dataIn = 32'h66; BE = 4'hF;
    cycle();
    check("rdw_read_first", do1, 32'h55);
    check("rdw_write_first", do2, 32'h66);
    do_read(3);
    check("rdw_after_wf0", do1, 32'h66);
    check("rdw_after_wf1", do2, 32'h66);

    // Soft clear with a second request mid-sweep.
    for (int i = 0; i < 8; i++) do_write(i, 32'h1000 + 32'(i), 4'hF);
    idle_inputs();
    clr_req = 1;
    cycle();
    n = 0;
    while (b2 && n < 40) begin
      n++;
      clr_req = (n == 2);
      cycle();
    end
    check("soft_clear_len", 32'(n), 32'd8);
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      do_read(i);
      check("soft_clear_val", do2, 32'hFF);
    end

    // Reset mid-sweep restarts the sweep; reads during it are dropped.
    idle_inputs();
    clr_req = 1;
    cycle();
    idle_inputs();
    CS = 1; RD = 1;
    repeat (2) cycle();
    assert_reset();
    cycle();
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    while (b2 && n < 40) begin
      n++;
      addr = 3'(n);
      cycle();
    end
    check("reset_mid_sweep_len", 32'(n), 32'd8);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      CS      = ($urandom_range(0, 3) != 0);
      WE      = $urandom_range(0, 1) == 1;
      RD      = $urandom_range(0, 1) == 1;
      BE      = 4'($urandom);
      dataIn  = $urandom;
      addr    = 3'($urandom);
      clr_req = ($urandom_range(0, 59) == 0);
      cycle();
    end

    idle_inputs();
    repeat (10) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
